// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared SIMON128/128 parameters, round function and FSM state type
package simon_pkg;

    localparam int W         = 64;
    localparam int N_RODADAS = 68;
    localparam int CNT_W     = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1;
    localparam int IDX_W     = 7;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DECIFRA = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    // Circular left rotate within one W-bit word; s is always a small constant
    function automatic logic [W-1:0] rotl(input logic [W-1:0] a, input int unsigned s);
        return (a << s) | (a >> (W - s));
    endfunction

    // SIMON round nonlinearity shared by encryptor and decryptor
    function automatic logic [W-1:0] f_simon(input logic [W-1:0] a);
        return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
    endfunction

endpackage

// File: rtl/rodada_simon_inv.sv
// rtl/rodada_simon_inv.sv - combinational inverse SIMON round {x,y},k -> {y, x^f(y)^k}
module rodada_simon_inv
    import simon_pkg::*;
(
    input  logic [2*W-1:0] bloco_i,
    input  logic [W-1:0]   k_i,
    output logic [2*W-1:0] bloco_o
);

    logic [W-1:0] x;
    logic [W-1:0] y;

    assign x = bloco_i[2*W-1:W];
    assign y = bloco_i[W-1:0];

    // Undo the forward round {y ^ f(x) ^ k, x}: the old x is recovered from y
    assign bloco_o = {y, x ^ f_simon(y) ^ k_i};

endmodule

// File: rtl/simon_decifra.sv
// rtl/simon_decifra.sv - iterative SIMON128/128 decryptor, one inverse round per clock
module simon_decifra
    import simon_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             entrada_valida_i,
    output logic             entrada_pronta_o,
    input  logic [2*W-1:0]   cifrado_i,
    output logic [IDX_W-1:0] idx_kj_o,
    input  logic [W-1:0]     kj_i,
    output logic             saida_valida_o,
    input  logic             saida_pronta_i,
    output logic [2*W-1:0]   texto_o
);

    estado_t          estado_q, estado_d;
    logic [2*W-1:0]   bloco_q, bloco_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   rodada_out;

    rodada_simon_inv u_rodada (
        .bloco_i (bloco_q),
        .k_i     (kj_i),
        .bloco_o (rodada_out)
    );

    // State, block and round-counter registers; reset drops any partial block
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado_q <= OCIOSO;
            bloco_q  <= '0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            bloco_q  <= bloco_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, datapath select and handshake outputs
    always_comb begin
        estado_d         = estado_q;
        bloco_d          = bloco_q;
        cnt_d            = cnt_q;
        entrada_pronta_o = 1'b0;
        saida_valida_o   = 1'b0;
        idx_kj_o         = '0;
        case (estado_q)
            OCIOSO: begin
                entrada_pronta_o = 1'b1;
                if (entrada_valida_i) begin
                    bloco_d  = cifrado_i;
                    cnt_d    = CNT_W'(N_RODADAS - 1);
                    estado_d = DECIFRA;
                end
            end
            DECIFRA: begin
                // Keys are consumed last-to-first, the reverse of the encryptor
                idx_kj_o = IDX_W'(cnt_q);
                bloco_d  = rodada_out;
                if (cnt_q == '0) begin
                    estado_d = PRONTO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PRONTO: begin
                saida_valida_o = 1'b1;
                if (saida_pronta_i) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign texto_o = bloco_q;

endmodule

// File: tb/tb_simon_decifra.sv
// tb/tb_simon_decifra.sv - self-checking bench for simon_decifra against a SIMON reference model
module tb_simon_decifra;
    import simon_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             entrada_valida_i;
    logic             entrada_pronta_o;
    logic [2*W-1:0]   cifrado_i;
    logic [IDX_W-1:0] idx_kj_o;
    logic [W-1:0]     kj_i;
    logic             saida_valida_o;
    logic             saida_pronta_i;
    logic [2*W-1:0]   texto_o;

    simon_decifra dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .entrada_valida_i (entrada_valida_i),
        .entrada_pronta_o (entrada_pronta_o),
        .cifrado_i        (cifrado_i),
        .idx_kj_o         (idx_kj_o),
        .kj_i             (kj_i),
        .saida_valida_o   (saida_valida_o),
        .saida_pronta_i   (saida_pronta_i),
        .texto_o          (texto_o)
    );

    // 10 ns clock
    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] rk [0:N_RODADAS-1];

    // Combinational key store lookup
    always_comb begin
        kj_i = '0;
        if (idx_kj_o < 7'(N_RODADAS)) kj_i = rk[idx_kj_o];
    end

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ror(input logic [W-1:0] a, input int unsigned s);
        return rotl(a, W - s);
    endfunction

    // Standard SIMON128/128 key schedule (m = 2, constant sequence z2)
    task automatic expand_key(input logic [2*W-1:0] key);
        logic [61:0]  z2;
        logic [W-1:0] t;
        z2 = 62'b10101111_01110000_00110100_10011000_10100001_00011111_10010110_110011;
        rk[0] = key[W-1:0];
        rk[1] = key[2*W-1:W];
        for (int i = 2; i < N_RODADAS; i++) begin
            t = ror(rk[i-1], 3);
            t = t ^ ror(t, 1);
            rk[i] = ~rk[i-2] ^ t ^ {63'b0, z2[61 - ((i - 2) % 62)]} ^ 64'd3;
        end
    endtask

    function automatic logic [2*W-1:0] model_encrypt(input logic [2*W-1:0] pt);
        logic [W-1:0] x, y, t;
        x = pt[2*W-1:W];
        y = pt[W-1:0];
        for (int i = 0; i < N_RODADAS; i++) begin
            t = x;
            x = y ^ f_simon(x) ^ rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [2*W-1:0] model_decrypt(input logic [2*W-1:0] ct);
        logic [W-1:0] x, y, t;
        x = ct[2*W-1:W];
        y = ct[W-1:0];
        for (int i = N_RODADAS - 1; i >= 0; i--) begin
            t = y;
            y = x ^ f_simon(y) ^ rk[i];
            x = t;
        end
        return {x, y};
    endfunction

    // Transaction-level model: 0 idle, 1 busy with rounds left, 2 result waiting
    int             m_phase = 0;
    int             m_left  = 0;
    logic [2*W-1:0] m_exp   = '0;
    bit             m_on    = 1'b0;

    // Advance the model on each clock edge from the inputs presented to the DUT
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_phase <= 0;
            m_left  <= 0;
            m_exp   <= '0;
        end else begin
            case (m_phase)
                0: if (entrada_valida_i) begin
                    m_phase <= 1;
                    m_left  <= N_RODADAS;
                    m_exp   <= model_decrypt(cifrado_i);
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                default: if (saida_pronta_i) m_phase <= 0;
            endcase
        end
    end

    // Compare DUT outputs with the model on every falling edge
    always @(negedge clk_i) begin
        if (m_on) begin
            chk("entrada_pronta", {127'b0, entrada_pronta_o}, {127'b0, m_phase == 0});
            chk("saida_valida", {127'b0, saida_valida_o}, {127'b0, m_phase == 2});
            chk("idx_kj", {121'b0, idx_kj_o}, (m_phase == 1) ? 128'(m_left - 1) : 128'd0);
            if (m_phase == 2) chk("texto", texto_o, m_exp);
        end
    end

    bit           rec = 1'b0;
    logic [6:0]   idx_log [$];

    // Log key indices while the DUT reports neither ready nor valid
    always @(negedge clk_i) begin
        if (rec && !entrada_pronta_o && !saida_valida_o) idx_log.push_back(idx_kj_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [2*W-1:0] c);
        bit ok;
        ok = 1'b0;
        entrada_valida_i = 1'b1;
        cifrado_i        = c;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (entrada_pronta_o) ok = 1'b1;
            tick();
        end
        entrada_valida_i = 1'b0;
        cifrado_i        = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL offer_timeout: got no entrada_pronta expected accept within 300 cycles");
        end
    endtask

    task automatic consume(input int stall, input logic [2*W-1:0] exp, output int wait_n);
        bit got;
        got    = 1'b0;
        wait_n = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (saida_valida_o) got = 1'b1;
            else begin
                tick();
                wait_n++;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL output_timeout: got no saida_valida expected within 300 cycles");
        end else begin
            for (int s = 0; s < stall; s++) begin
                saida_pronta_i = 1'b0;
                chk("hold_texto", texto_o, exp);
                chk("hold_pronta", {127'b0, entrada_pronta_o}, 128'd0);
                tick();
            end
            chk("result", texto_o, exp);
            saida_pronta_i = 1'b1;
            tick();
            saida_pronta_i = 1'b0;
        end
    endtask

    localparam logic [2*W-1:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [2*W-1:0] KAT_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
    localparam logic [2*W-1:0] KAT_PT  = 128'h6373656420737265_6c6c657661727420;

    initial begin
        int             w;
        logic [2*W-1:0] pt, pt2, ct, ct2, key;

        rst_i            = 1'b1;
        entrada_valida_i = 1'b0;
        cifrado_i        = '0;
        saida_pronta_i   = 1'b0;
        expand_key(KAT_KEY);
        tick();
        tick();
        m_on = 1'b1;
        chk("rst_pronta", {127'b0, entrada_pronta_o}, 128'd1);
        chk("rst_valida", {127'b0, saida_valida_o}, 128'd0);
        chk("rst_texto", texto_o, 128'd0);
        chk("rst_idx", {121'b0, idx_kj_o}, 128'd0);
        rst_i = 1'b0;
        tick();

        // Pin the reference model to the published test vector
        chk("model_enc_kat", model_encrypt(KAT_PT), KAT_CT);
        chk("model_dec_kat", model_decrypt(KAT_CT), KAT_PT);

        // Known answer, latency and key order
        rec = 1'b1;
        offer(KAT_CT);
        consume(0, KAT_PT, w);
        rec = 1'b0;
        chk("latency", 128'(w), 128'(N_RODADAS));
        chk("idx_count", 128'(idx_log.size()), 128'(N_RODADAS));
        for (int i = 0; i < idx_log.size() && i < N_RODADAS; i++)
            chk("idx_order", {121'b0, idx_log[i]}, 128'(N_RODADAS - 1 - i));

        // Backpressure with a new block waiting; it is taken right after the handshake
        pt  = 128'h0123456789abcdef_fedcba9876543210;
        pt2 = 128'hdeadbeefcafef00d_0badc0de12345678;
        ct  = model_encrypt(pt);
        ct2 = model_encrypt(pt2);
        offer(ct);
        entrada_valida_i = 1'b1;
        cifrado_i        = ct2;
        consume(10, pt, w);
        chk("bp_idle", {127'b0, entrada_pronta_o}, 128'd1);
        tick();
        entrada_valida_i = 1'b0;
        chk("bp_accept_pronta", {127'b0, entrada_pronta_o}, 128'd0);
        chk("bp_accept_idx", {121'b0, idx_kj_o}, 128'(N_RODADAS - 1));
        consume(0, pt2, w);
        chk("bp_second_latency", 128'(w), 128'(N_RODADAS));

        // Back-to-back: second block offered continuously through the first one
        offer(ct2);
        entrada_valida_i = 1'b1;
        cifrado_i        = KAT_CT;
        consume(0, pt2, w);
        tick();
        entrada_valida_i = 1'b0;
        chk("b2b_accept_idx", {121'b0, idx_kj_o}, 128'(N_RODADAS - 1));
        consume(0, KAT_PT, w);

        // Reset at round 30 discards the partial block
        offer(ct);
        repeat (30) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_pronta", {127'b0, entrada_pronta_o}, 128'd1);
        chk("midrst_valida", {127'b0, saida_valida_o}, 128'd0);
        chk("midrst_texto", texto_o, 128'd0);
        chk("midrst_idx", {121'b0, idx_kj_o}, 128'd0);
        offer(ct);
        consume(0, pt, w);

        // Random round trips with fresh keys
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(key);
            ct = model_encrypt(pt);
            if (n % 100 == 0) chk("model_roundtrip", model_decrypt(ct), pt);
            offer(ct);
            consume(int'($urandom_range(0, 2)), pt, w);
        end

        m_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
